// File: rtl/core_ldst_router.sv
// Load/store router: steers core requests to DATA memory or IO by address,
// tracks outstanding reads and returns in-order registered responses.
module core_ldst_router #(
  parameter int unsigned P_DEPTH     = 4,
  parameter int unsigned P_CNT_W     = 4,
  parameter int unsigned P_IO_ENABLE = 1
) (
  input  logic               iCLOCK,
  input  logic               inRESET,
  // IO start address configuration
  input  logic               iSYSINFO_IOSR_VALID,
  input  logic [31:0]        iSYSINFO_IOSR,
  // core load/store request
  input  logic               iLDST_REQ,
  output logic               oLDST_BUSY,
  input  logic [1:0]         iLDST_ORDER,
  input  logic               iLDST_RW,
  input  logic [13:0]        iLDST_TID,
  input  logic [1:0]         iLDST_MMUMOD,
  input  logic [31:0]        iLDST_PDT,
  input  logic [31:0]        iLDST_ADDR,
  input  logic [31:0]        iLDST_DATA,
  // core load/store response
  output logic               oLDST_VALID,
  output logic               oLDST_PAGEFAULT,
  output logic [63:0]        oLDST_DATA,
  output logic [27:0]        oLDST_MMU_FLAGS,
  // DATA request side
  output logic               oDATA_REQ,
  input  logic               iDATA_LOCK,
  output logic [1:0]         oDATA_ORDER,
  output logic               oDATA_RW,
  output logic [13:0]        oDATA_TID,
  output logic [1:0]         oDATA_MMUMOD,
  output logic [31:0]        oDATA_PDT,
  output logic [31:0]        oDATA_ADDR,
  output logic [31:0]        oDATA_DATA,
  // DATA response side
  input  logic               iDATA_VALID,
  input  logic               iDATA_PAGEFAULT,
  input  logic [63:0]        iDATA_DATA,
  input  logic [27:0]        iDATA_MMU_FLAGS,
  // IO request side
  output logic               oIO_REQ,
  input  logic               iIO_BUSY,
  output logic [1:0]         oIO_ORDER,
  output logic               oIO_RW,
  output logic [31:0]        oIO_ADDR,
  output logic [31:0]        oIO_DATA,
  // IO response side
  input  logic               iIO_VALID,
  input  logic [31:0]        iIO_DATA,
  // status
  output logic [P_CNT_W-1:0] oOUTSTANDING,
  output logic               oPROTOCOL_ERR
);

  localparam logic               CH_DATA   = 1'b0;
  localparam logic               CH_IO     = 1'b1;
  localparam logic [P_CNT_W-1:0] DEPTH_MAX = P_CNT_W'(P_DEPTH);
  localparam logic [P_CNT_W-1:0] CNT_ONE   = P_CNT_W'(1);
  localparam logic [P_CNT_W-1:0] CNT_ZERO  = '0;
  localparam logic               IO_ON     = (P_IO_ENABLE != 0);

  logic               iosrValid;
  logic [31:0]        iosr;
  logic [P_CNT_W-1:0] count;
  logic               curChan;

  logic               ioNotReady;
  logic               target;
  logic               countFull;
  logic               countZero;
  logic               switchHazard;
  logic               targetLocked;
  logic               busyReq;
  logic               busyIdle;
  logic               accept;
  logic               readAccept;
  logic               rspCur;
  logic               rspOther;
  logic               complete;
  logic               dropped;

  // Routing decision and stall conditions for the current request
  always_comb begin
    ioNotReady   = IO_ON && !iosrValid;
    target       = (IO_ON && (iLDST_ADDR >= iosr)) ? CH_IO : CH_DATA;
    countFull    = (count == DEPTH_MAX);
    countZero    = (count == CNT_ZERO);
    switchHazard = !countZero && (target != curChan);
    targetLocked = (target == CH_DATA) ? iDATA_LOCK : iIO_BUSY;
    busyReq      = ioNotReady || (countFull && iLDST_RW) || switchHazard || targetLocked;
    busyIdle     = ioNotReady || ((target == CH_DATA) && iDATA_LOCK);
  end

  // Issue handshake: accepted requests go out in the same cycle
  always_comb begin
    oLDST_BUSY = iLDST_REQ ? busyReq : busyIdle;
    accept     = iLDST_REQ && !busyReq;
    readAccept = accept && iLDST_RW;
    oDATA_REQ  = accept && (target == CH_DATA);
    oIO_REQ    = accept && (target == CH_IO);
  end

  // Response qualification against the channel currently in use
  always_comb begin
    rspCur   = (curChan == CH_DATA) ? iDATA_VALID : iIO_VALID;
    rspOther = (curChan == CH_DATA) ? iIO_VALID : iDATA_VALID;
    complete = rspCur && !countZero;
    dropped  = rspOther || (rspCur && countZero);
  end

  // Request fields are broadcast to both targets; only the strobes differ
  assign oDATA_ORDER  = iLDST_ORDER;
  assign oDATA_RW     = iLDST_RW;
  assign oDATA_TID    = iLDST_TID;
  assign oDATA_MMUMOD = iLDST_MMUMOD;
  assign oDATA_PDT    = iLDST_PDT;
  assign oDATA_ADDR   = iLDST_ADDR;
  assign oDATA_DATA   = iLDST_DATA;
  assign oIO_ORDER    = iLDST_ORDER;
  assign oIO_RW       = iLDST_RW;
  assign oIO_ADDR     = iLDST_ADDR;
  assign oIO_DATA     = iLDST_DATA;

  assign oOUTSTANDING = count;

  // IO start address register; a reload only affects later requests
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      iosrValid <= 1'b0;
      iosr      <= 32'h0;
    end else if (iSYSINFO_IOSR_VALID) begin
      iosrValid <= 1'b1;
      iosr      <= iSYSINFO_IOSR;
    end
  end

  // Active channel follows the last accepted request
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      curChan <= CH_DATA;
    end else if (accept) begin
      curChan <= target;
    end
  end

  // Outstanding read count; accept is already blocked when full and
  // completion is gated by a non-zero count, so it cannot wrap
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      count <= '0;
    end else if (readAccept && !complete) begin
      count <= count + CNT_ONE;
    end else if (!readAccept && complete) begin
      count <= count - CNT_ONE;
    end
  end

  // Sticky flag for responses nobody asked for
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      oPROTOCOL_ERR <= 1'b0;
    end else if (dropped) begin
      oPROTOCOL_ERR <= 1'b1;
    end
  end

  // Merged response port, one cycle behind the target; payload holds when idle
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      oLDST_VALID     <= 1'b0;
      oLDST_PAGEFAULT <= 1'b0;
      oLDST_DATA      <= 64'h0;
      oLDST_MMU_FLAGS <= 28'h0;
    end else begin
      oLDST_VALID <= complete;
      if (complete) begin
        if (curChan == CH_DATA) begin
          oLDST_PAGEFAULT <= iDATA_PAGEFAULT;
          oLDST_DATA      <= iDATA_DATA;
          oLDST_MMU_FLAGS <= iDATA_MMU_FLAGS;
        end else begin
          oLDST_PAGEFAULT <= 1'b0;
          oLDST_DATA      <= {32'h0, iIO_DATA};
          oLDST_MMU_FLAGS <= 28'h0;
        end
      end
    end
  end

endmodule
